// File: rtl/shared_pkg.sv
// Constants and types shared by the FIFO write-side blocks.
// FIFO_WIDTH sets the FIFO data width. The DEF_* values are the arbiter's default parameters.
package shared_pkg;

  localparam int FIFO_WIDTH    = 16;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker. The search starts at (ptr+1) mod NUM_REQ.
// Outputs are the first set request bit as a one-hot vector and as an index.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [IDX_W-1:0]   winner_idx
);

  logic             found;
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    winner_oh  = '0;
    winner_idx = '0;
    found      = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    // k runs 1..NUM_REQ, so the current pointer holder is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found               = 1'b1;
        winner_oh[cand_idx] = 1'b1;
        winner_idx          = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter that shares one FIFO write port between NUM_REQ requesters.
// A grant lasts until the last beat of a packet or until MAX_BURST beats, whichever comes first.
// fifo_full gates every write. Sticky flags record FIFO overflow and missing write acks.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = shared_pkg::DEF_NUM_REQ,
  parameter int MAX_BURST  = shared_pkg::DEF_MAX_BURST,
  parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic                          busy,
  output logic                          ovf_err,
  output logic                          ack_err
);

  import shared_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Handshake: a beat moves only when hs is high, that is when the owner has
  // req_valid set, the FIFO is not full and we are in GRANT. req_ready and
  // fifo_wr_en are both hs, so a producer sees its beat taken in the same cycle.
  arb_state_e         state_q;
  arb_state_e         state_d;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic               wr_en_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;
  logic               hs;
  logic               release_pkt;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .winner_oh  (pick_oh),
    .winner_idx (pick_idx)
  );

  assign any_req     = |req_valid;
  assign hs          = (state_q == GRANT) && req_valid[owner_q] && !fifo_full;
  assign release_pkt = hs && (req_last[owner_q] || (beat_cnt_q == CNT_W'(MAX_BURST - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)     state_d = GRANT;
      GRANT:   if (release_pkt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q == GRANT);
    grant        = grant_q;
    fifo_wr_en   = hs;
    req_ready    = hs ? grant_q : '0;
    fifo_data_in = hs ? req_data[owner_q*FIFO_WIDTH +: FIFO_WIDTH] : '0;
  end

  // The pointer tracks the last winner, so the next search starts just after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      grant_q    <= pick_oh;
      owner_q    <= pick_idx;
      rr_ptr_q   <= pick_idx;
      beat_cnt_q <= '0;
    end else if (hs) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
      if (release_pkt) begin
        grant_q <= '0;
      end
    end
  end

  // The FIFO acks one cycle after each accepted write. A write with no ack behind it sets ack_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      ovf_err <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      wr_en_q <= hs;
      if (fifo_overflow)            ovf_err <= 1'b1;
      if (wr_en_q && !fifo_wr_ack)  ack_err <= 1'b1;
    end
  end

endmodule
